// File: rtl/rr_arb_codec.sv
// rr_arb_codec
//   Round-robin arbiter with one-hot and binary grant outputs. It also holds two
//   stand-alone index<->one-hot converters. The only state is the one-hot
//   round-robin priority pointer. Everything else is combinational.
//
// Ports
//   clk_i          clock
//   reset_i        asynchronous active-high reset; pointer returns to requester 0
//   request_i      per-requester request vector
//   update_lru_i   move the pointer past the current grant on the next edge
//   grant_oh_o     one-hot grant (all-zero when there is no request)
//   grant_idx_o    binary index of grant_oh_o (0 when there is no grant)
//   grant_valid_o  |request_i
//   dec_index_i    index to decode
//   dec_one_hot_o  decoded one-hot (zero when the index is out of range)
//   enc_one_hot_i  one-hot to encode
//   enc_index_o    OR of the mapped indices of all set bits
module rr_arb_codec #(
  parameter int NUM_REQUESTERS = 4,
  parameter int GRANT_IDX_W    = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1,
  parameter int NUM_SIGNALS    = 4,
  parameter int INDEX_WIDTH    = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1,
  parameter     DIRECTION      = "LSB0"
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQUESTERS-1:0] request_i,
  input  logic                      update_lru_i,
  output logic [NUM_REQUESTERS-1:0] grant_oh_o,
  output logic [GRANT_IDX_W-1:0]    grant_idx_o,
  output logic                      grant_valid_o,
  input  logic [INDEX_WIDTH-1:0]    dec_index_i,
  output logic [NUM_SIGNALS-1:0]    dec_one_hot_o,
  input  logic [NUM_SIGNALS-1:0]    enc_one_hot_i,
  output logic [INDEX_WIDTH-1:0]    enc_index_o
);

  localparam bit MSB0 = (DIRECTION == "MSB0");

  logic [NUM_REQUESTERS-1:0] priority_q, priority_d;
  logic [NUM_REQUESTERS-1:0] grant;
  logic [GRANT_IDX_W-1:0]    ptr_idx;
  logic                      found;

  // Round-robin search. The search starts at the pointer position and goes up,
  // wrapping at the top. The first active request wins.
  always_comb begin
    ptr_idx = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++)
      if (priority_q[i]) ptr_idx = ptr_idx | GRANT_IDX_W'(i);
    grant = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQUESTERS; off++) begin
      int c;
      c = (int'(ptr_idx) + off) % NUM_REQUESTERS;
      if (!found && request_i[c]) begin
        grant[c] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx_o = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++)
      if (grant[i]) grant_idx_o = grant_idx_o | GRANT_IDX_W'(i);
  end

  assign grant_oh_o    = grant;
  assign grant_valid_o = |request_i;

  // The just-granted requester becomes lowest priority. This is done by rotating
  // the grant left by one. The shift/OR form also covers a single requester,
  // where the pointer stays 1.
  always_comb begin
    priority_d = priority_q;
    if (update_lru_i && (|grant))
      priority_d = (grant << 1) | (grant >> (NUM_REQUESTERS - 1));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) priority_q <= NUM_REQUESTERS'(1);
    else         priority_q <= priority_d;
  end

  // Converters. Under MSB0 mapping, index i corresponds to bit NUM_SIGNALS-1-i.
  // An out-of-range decode index matches no bit, so the output is zero.
  always_comb begin
    dec_one_hot_o = '0;
    for (int i = 0; i < NUM_SIGNALS; i++)
      if (dec_index_i == INDEX_WIDTH'(i))
        dec_one_hot_o[MSB0 ? (NUM_SIGNALS - 1 - i) : i] = 1'b1;
  end

  // The encoder ORs the indices of every set bit. Multi-hot input therefore
  // gives the OR of the indices, and all-zero input gives 0.
  always_comb begin
    enc_index_o = '0;
    for (int j = 0; j < NUM_SIGNALS; j++)
      if (enc_one_hot_i[j])
        enc_index_o = enc_index_o | INDEX_WIDTH'(MSB0 ? (NUM_SIGNALS - 1 - j) : j);
  end

endmodule

// File: tb/tb_rr_arb_codec.sv
module tb_rr_arb_codec;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] request;
  logic       update_lru;
  logic [1:0] dec_index;
  logic [2:0] dec_index6;
  logic [3:0] enc_one_hot;
  logic [5:0] enc_one_hot6;

  logic [3:0] g_l, g_m;
  logic [5:0] g_6;
  logic [1:0] gi_l, gi_m, gi_6;
  logic       gv_l, gv_m, gv_6;
  logic [3:0] d_l, d_m, d_1;
  logic [5:0] d_6;
  logic [1:0] e_l, e_m, e_1;
  logic [2:0] e_6;
  logic [0:0] g_1, gi_1;
  logic       gv_1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_arb_codec #(.NUM_REQUESTERS(4), .NUM_SIGNALS(4), .DIRECTION("LSB0")) u_l (
    .clk_i(clk), .reset_i(reset), .request_i(request), .update_lru_i(update_lru),
    .grant_oh_o(g_l), .grant_idx_o(gi_l), .grant_valid_o(gv_l),
    .dec_index_i(dec_index), .dec_one_hot_o(d_l),
    .enc_one_hot_i(enc_one_hot), .enc_index_o(e_l));

  rr_arb_codec #(.NUM_REQUESTERS(4), .NUM_SIGNALS(4), .DIRECTION("MSB0")) u_m (
    .clk_i(clk), .reset_i(reset), .request_i(request), .update_lru_i(update_lru),
    .grant_oh_o(g_m), .grant_idx_o(gi_m), .grant_valid_o(gv_m),
    .dec_index_i(dec_index), .dec_one_hot_o(d_m),
    .enc_one_hot_i(enc_one_hot), .enc_index_o(e_m));

  // Six requesters driven with the four-bit pattern zero-extended; six signals.
  rr_arb_codec #(.NUM_REQUESTERS(6), .NUM_SIGNALS(6), .DIRECTION("LSB0")) u_6 (
    .clk_i(clk), .reset_i(reset), .request_i({2'b00, request}), .update_lru_i(update_lru),
    .grant_oh_o(g_6), .grant_idx_o(gi_6), .grant_valid_o(gv_6),
    .dec_index_i(dec_index6), .dec_one_hot_o(d_6),
    .enc_one_hot_i(enc_one_hot6), .enc_index_o(e_6));

  rr_arb_codec #(.NUM_REQUESTERS(1), .NUM_SIGNALS(4), .DIRECTION("LSB0")) u_1 (
    .clk_i(clk), .reset_i(reset), .request_i(request[0]), .update_lru_i(update_lru),
    .grant_oh_o(g_1), .grant_idx_o(gi_1), .grant_valid_o(gv_1),
    .dec_index_i(dec_index), .dec_one_hot_o(d_1),
    .enc_one_hot_i(enc_one_hot), .enc_index_o(e_1));

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       upd;
    logic [3:0] exp_g;
    logic [1:0] exp_i;
    logic       exp_v;
  } arb_vec_t;

  typedef struct {
    logic [3:0] g;
    logic [1:0] i;
    logic       v;
    logic [3:0] req;
    string      tag;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  arb_vec_t av[];

  initial begin
    // The pointer advances to just past the grant whenever update_lru=1 and a grant exists.
    av = '{
      // The reset is held here, so the lowest active request wins.
      '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1},
      // Full request with update: the grant sweeps 0..3 and wraps.
      '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1},
      '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1},
      '{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1},
      '{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1},
      '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1},
      // The pointer is now at 1. The grant alternates within 1010.
      '{1'b0, 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1},
      '{1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b1},
      '{1'b0, 4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1},
      // The pointer is at 2. Grant requester 0 to move the pointer to 1.
      '{1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1},
      // The pointer holds while update_lru=0.
      '{1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1},
      '{1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1},
      '{1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1},
      '{1'b0, 4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1},
      '{1'b0, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1},
      // An idle cycle with update leaves the pointer at 2.
      '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0},
      '{1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1},
      // A mid-sequence reset returns the pointer to 0 at once.
      '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0},
      '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1},
      '{1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1},
      '{1'b0, 4'b1100, 1'b1, 4'b0100, 2'd2, 1'b1},
      '{1'b0, 4'b1100, 1'b1, 4'b1000, 2'd3, 1'b1},
      '{1'b0, 4'b1100, 1'b0, 4'b0100, 2'd2, 1'b1}
    };

    reset = 1'b1; request = '0; update_lru = 1'b0;
    dec_index = '0; dec_index6 = '0; enc_one_hot = '0; enc_one_hot6 = '0;
    #12;

    foreach (av[k]) begin
      @(posedge clk);
      #1;
      reset = av[k].rst; request = av[k].req; update_lru = av[k].upd;
      sb.push_back('{g: av[k].exp_g, i: av[k].exp_i, v: av[k].exp_v, req: av[k].req,
                     tag: $sformatf("v%0d", k)});
      @(negedge clk);
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL scoreboard_empty at vector %0d", k);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, " grant_oh"},    32'(g_l),  32'(e.g));
        chk({e.tag, " grant_idx"},   32'(gi_l), 32'(e.i));
        chk({e.tag, " grant_valid"}, 32'(gv_l), 32'(e.v));
        chk({e.tag, " msb0_grant"},  32'(g_m),  32'(e.g));
        chk({e.tag, " r6_grant"},    32'(g_6),  32'({2'b00, e.g}));
        chk({e.tag, " r6_idx"},      32'(gi_6), 32'(e.i));
        chk({e.tag, " r1_grant"},    32'(g_1),  32'(e.req[0]));
        chk({e.tag, " r1_idx"},      32'(gi_1), 32'd0);
        chk({e.tag, " r1_valid"},    32'(gv_1), 32'(e.req[0]));
      end
    end
    reset = 1'b0; update_lru = 1'b0;

    // Decoder: LSB0, MSB0 and six-signal with out-of-range indices.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] el, em;
      el = 4'b0001 << i;
      em = 4'b1000 >> i;
      dec_index = 2'(i);
      #1;
      chk($sformatf("dec_lsb0 idx%0d", i), 32'(d_l), 32'(el));
      chk($sformatf("dec_msb0 idx%0d", i), 32'(d_m), 32'(em));
      chk($sformatf("dec_r1 idx%0d", i),   32'(d_1), 32'(el));
    end
    for (int i = 0; i < 8; i++) begin
      logic [5:0] e6;
      e6 = (i < 6) ? (6'b000001 << i) : 6'b000000;
      dec_index6 = 3'(i);
      #1;
      chk($sformatf("dec_n6 idx%0d", i), 32'(d_6), 32'(e6));
    end

    // Encoder: {one_hot, expected LSB0, expected MSB0}.
    begin
      logic [7:0] et [8];
      et = '{8'b0001_00_11, 8'b0010_01_10, 8'b0100_10_01, 8'b1000_11_00,
             8'b0000_00_00, 8'b0110_11_11, 8'b1001_11_11, 8'b0011_01_11};
      foreach (et[k]) begin
        enc_one_hot = et[k][7:4];
        #1;
        chk($sformatf("enc_lsb0 %b", et[k][7:4]), 32'(e_l), 32'(et[k][3:2]));
        chk($sformatf("enc_msb0 %b", et[k][7:4]), 32'(e_m), 32'(et[k][1:0]));
      end
    end
    enc_one_hot6 = 6'b100000; #1; chk("enc_n6 100000", 32'(e_6), 32'd5);
    enc_one_hot6 = 6'b010001; #1; chk("enc_n6 010001", 32'(e_6), 32'd4);
    enc_one_hot6 = 6'b001100; #1; chk("enc_n6 001100", 32'(e_6), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
